// File: rtl/entity_resolver_pkg.sv
// Shared definitions for the entity resolver: collision flag positions,
// tile blockType encodings, default solidity masks, FSM states and helpers.
package entity_resolver_pkg;

    // Bit positions inside the {top, right, bottom, left} collision vector
    localparam int unsigned COL_TOP   = 3;
    localparam int unsigned COL_RIGHT = 2;
    localparam int unsigned COL_BOT   = 1;
    localparam int unsigned COL_LEFT  = 0;

    // Tile-map blockType encodings
    localparam logic [2:0] BT_EMPTY  = 3'd0;
    localparam logic [2:0] BT_SOLID  = 3'd1;
    localparam logic [2:0] BT_ONEWAY = 3'd2;

    // Default masks: type 1 is solid everywhere, type 2 only stops falling
    localparam logic [7:0] DEF_SOLID_MASK  = 8'b0000_0010;
    localparam logic [7:0] DEF_ONEWAY_MASK = 8'b0000_0100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HPROBE = 3'd1,
        ST_HWAIT  = 3'd2,
        ST_VPROBE = 3'd3,
        ST_VWAIT  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Probes needed to cover an edge of len pixels: one per tile step plus the far corner
    function automatic int unsigned num_probes(input int unsigned len, input int unsigned tile);
        return ((len - 1) + (tile - 1)) / tile + 1;
    endfunction

    // A probe blocks motion if the type is solid, or one-way while falling
    function automatic logic probe_collides(input logic [2:0] bt,
                                            input logic [7:0] solid_mask,
                                            input logic [7:0] oneway_mask,
                                            input logic       down);
        return solid_mask[bt] | (oneway_mask[bt] & down);
    endfunction

endpackage

// File: rtl/entity_resolver_prober.sv
// edge_prober: walks one hitbox edge issuing one tile-map probe per cycle and
// ORs together the collide results that come back MAP_LAT cycles later.
module edge_prober
    import entity_resolver_pkg::*;
#(
    parameter int unsigned TILE        = 32,
    parameter int unsigned MAP_LAT     = 1,
    parameter logic [7:0]  SOLID_MASK  = DEF_SOLID_MASK,
    parameter logic [7:0]  ONEWAY_MASK = DEF_ONEWAY_MASK
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       launch_i,
    input  logic       vert_i,
    input  logic       down_i,
    input  logic [9:0] fixed_i,
    input  logic [9:0] first_i,
    input  logic [9:0] last_i,
    input  logic [7:0] np_i,
    input  logic [2:0] map_type_i,
    output logic [9:0] map_x_o,
    output logic [9:0] map_y_o,
    output logic       map_req_o,
    output logic       hit_o
);

    localparam logic [9:0] STEP = 10'(TILE);

    logic               req_q;
    logic [7:0]         cnt_q;
    logic [7:0]         np_q;
    logic [9:0]         var_q;
    logic [9:0]         last_q;
    logic [9:0]         fixed_q;
    logic [9:0]         map_x_q;
    logic [9:0]         map_y_q;
    logic               vert_q;
    logic               down_q;
    logic               acc_q;
    logic [MAP_LAT-1:0] vld_q;

    logic [9:0]         var_d;
    logic               tail_hit_s;

    // Next probe coordinate along the edge and the latency-aligned collide result
    always_comb begin
        if (cnt_q + 8'd1 == np_q - 8'd1) begin
            var_d = last_q;
        end else begin
            var_d = var_q + STEP;
        end
        tail_hit_s = vld_q[MAP_LAT-1] &
                     probe_collides(map_type_i, SOLID_MASK, ONEWAY_MASK, down_q);
        hit_o      = acc_q | tail_hit_s;
    end

    // Probe sequencer and collide accumulator; launch restarts both for a new phase
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q   <= 1'b0;
            cnt_q   <= 8'd0;
            np_q    <= 8'd0;
            var_q   <= 10'd0;
            last_q  <= 10'd0;
            fixed_q <= 10'd0;
            map_x_q <= 10'd0;
            map_y_q <= 10'd0;
            vert_q  <= 1'b0;
            down_q  <= 1'b0;
            acc_q   <= 1'b0;
        end else if (launch_i) begin
            req_q   <= 1'b1;
            cnt_q   <= 8'd0;
            np_q    <= np_i;
            var_q   <= first_i;
            last_q  <= last_i;
            fixed_q <= fixed_i;
            vert_q  <= vert_i;
            down_q  <= down_i;
            acc_q   <= 1'b0;
            map_x_q <= vert_i ? first_i : fixed_i;
            map_y_q <= vert_i ? fixed_i : first_i;
        end else begin
            if (req_q) begin
                if (cnt_q == np_q - 8'd1) begin
                    req_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_q + 8'd1;
                    var_q   <= var_d;
                    map_x_q <= vert_q ? var_d : fixed_q;
                    map_y_q <= vert_q ? fixed_q : var_d;
                end
            end
            if (tail_hit_s) begin
                acc_q <= 1'b1;
            end
        end
    end

    // Valid pipeline that marks which map_type cycles answer one of our probes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= {MAP_LAT{1'b0}};
        end else begin
            vld_q[0] <= req_q;
            for (int i = 1; i < MAP_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign map_x_o   = map_x_q;
    assign map_y_o   = map_y_q;
    assign map_req_o = req_q;

endmodule

// File: rtl/entity_resolver.sv
// entity_resolver: moves a hitbox horizontally then vertically, probing the
// tile map along each leading edge and snapping to the tile boundary on contact.
module entity_resolver
    import entity_resolver_pkg::*;
#(
    parameter int unsigned HB_W        = 32,
    parameter int unsigned HB_H        = 32,
    parameter int unsigned TILE        = 32,
    parameter int unsigned SPD_W       = 5,
    parameter int unsigned MAP_LAT     = 1,
    parameter logic [7:0]  SOLID_MASK  = DEF_SOLID_MASK,
    parameter logic [7:0]  ONEWAY_MASK = DEF_ONEWAY_MASK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [9:0]       x_pos,
    input  logic [9:0]       y_pos,
    input  logic [SPD_W-1:0] x_spd,
    input  logic [SPD_W-1:0] y_spd,
    input  logic             x_dir,
    input  logic             y_dir,
    output logic [9:0]       map_x,
    output logic [9:0]       map_y,
    output logic             map_req,
    input  logic [2:0]       map_type,
    output logic             busy,
    output logic             done,
    output logic [3:0]       col,
    output logic [9:0]       x_next,
    output logic [9:0]       y_next
);

    localparam int unsigned NP_V   = num_probes(HB_H, TILE);
    localparam int unsigned NP_H   = num_probes(HB_W, TILE);
    localparam logic [7:0]  NPV8   = 8'(NP_V);
    localparam logic [7:0]  NPH8   = 8'(NP_H);
    localparam logic [7:0]  NPV_M1 = 8'(NP_V - 1);
    localparam logic [7:0]  NPH_M1 = 8'(NP_H - 1);
    localparam logic [7:0]  LAT_M1 = 8'(MAP_LAT - 1);
    localparam logic [9:0]  HBW    = 10'(HB_W);
    localparam logic [9:0]  HBH    = 10'(HB_H);
    localparam logic [9:0]  HBW_M1 = 10'(HB_W - 1);
    localparam logic [9:0]  HBH_M1 = 10'(HB_H - 1);
    localparam logic [9:0]  TMASK  = 10'(TILE - 1);
    localparam logic [3:0]  F_TOP  = 4'(1 << COL_TOP);
    localparam logic [3:0]  F_RGT  = 4'(1 << COL_RIGHT);
    localparam logic [3:0]  F_BOT  = 4'(1 << COL_BOT);
    localparam logic [3:0]  F_LFT  = 4'(1 << COL_LEFT);

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [9:0] x_q, y_q, xs_q, ys_q, xr_q;
    logic       xd_q, yd_q;
    logic [3:0] hcol_q;
    logic       busy_q, done_q;
    logic [3:0] col_q;
    logic [9:0] x_next_q, y_next_q;

    logic [9:0] sx_s, sy_s, sxs_s, sys_s;
    logic       sxd_s, syd_s;
    logic [9:0] nx_s, ny_s, x_res_s, y_res_s, xb_s;
    logic [3:0] hcol_s, vcol_s;
    logic       go_s, h_last_s, hit_s;
    logic       launch_s, vert_s, down_s;
    logic [9:0] fixed_s, first_s, last_s;
    logic [7:0] np_s;

    // In IDLE the raw inputs drive the first phase; afterwards the latched copies do
    always_comb begin
        if (state_q == ST_IDLE) begin
            sx_s  = x_pos;
            sy_s  = y_pos;
            sxs_s = 10'(x_spd);
            sys_s = 10'(y_spd);
            sxd_s = x_dir;
            syd_s = y_dir;
        end else begin
            sx_s  = x_q;
            sy_s  = y_q;
            sxs_s = xs_q;
            sys_s = ys_q;
            sxd_s = xd_q;
            syd_s = yd_q;
        end
        nx_s = sxd_s ? (sx_s + sxs_s) : (sx_s - sxs_s);
        ny_s = syd_s ? (sy_s - sys_s) : (sy_s + sys_s);
    end

    // Snap positions back to the tile boundary when the phase reported contact
    always_comb begin
        if (hit_s) begin
            if (sxd_s) begin
                x_res_s = ((nx_s + HBW_M1) & ~TMASK) - HBW;
                hcol_s  = F_RGT;
            end else begin
                x_res_s = (nx_s | TMASK) + 10'd1;
                hcol_s  = F_LFT;
            end
            if (syd_s) begin
                y_res_s = ((ny_s - HBH_M1) | TMASK) + HBH;
                vcol_s  = F_TOP;
            end else begin
                y_res_s = (ny_s & ~TMASK) - 10'd1;
                vcol_s  = F_BOT;
            end
        end else begin
            x_res_s = nx_s;
            y_res_s = ny_s;
            hcol_s  = 4'b0000;
            vcol_s  = 4'b0000;
        end
    end

    // Prober launch: horizontal edge from IDLE, vertical edge from IDLE or end of HWAIT
    always_comb begin
        go_s     = (state_q == ST_IDLE) && start;
        h_last_s = (state_q == ST_HWAIT) && (cnt_q == LAT_M1);
        if (state_q == ST_IDLE) begin
            xb_s = x_pos;
        end else if (state_q == ST_HWAIT) begin
            xb_s = x_res_s;
        end else begin
            xb_s = xr_q;
        end
        launch_s = 1'b0;
        vert_s   = 1'b0;
        down_s   = 1'b0;
        fixed_s  = 10'd0;
        first_s  = 10'd0;
        last_s   = 10'd0;
        np_s     = 8'd0;
        if (go_s && (sxs_s != 10'd0)) begin
            launch_s = 1'b1;
            fixed_s  = sxd_s ? (nx_s + HBW_M1) : nx_s;
            first_s  = sy_s - HBH_M1;
            last_s   = sy_s;
            np_s     = NPV8;
        end else if ((go_s || h_last_s) && (sys_s != 10'd0)) begin
            launch_s = 1'b1;
            vert_s   = 1'b1;
            down_s   = ~syd_s;
            fixed_s  = syd_s ? (ny_s - HBH_M1) : ny_s;
            first_s  = xb_s;
            last_s   = xb_s + HBW_M1;
            np_s     = NPH8;
        end else begin
            launch_s = 1'b0;
        end
    end

    edge_prober #(
        .TILE        (TILE),
        .MAP_LAT     (MAP_LAT),
        .SOLID_MASK  (SOLID_MASK),
        .ONEWAY_MASK (ONEWAY_MASK)
    ) u_prober (
        .clk_i      (clk),
        .rst_i      (rst),
        .launch_i   (launch_s),
        .vert_i     (vert_s),
        .down_i     (down_s),
        .fixed_i    (fixed_s),
        .first_i    (first_s),
        .last_i     (last_s),
        .np_i       (np_s),
        .map_type_i (map_type),
        .map_x_o    (map_x),
        .map_y_o    (map_y),
        .map_req_o  (map_req),
        .hit_o      (hit_s)
    );

    // Phase sequencing FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            xs_q     <= 10'd0;
            ys_q     <= 10'd0;
            xd_q     <= 1'b0;
            yd_q     <= 1'b0;
            xr_q     <= 10'd0;
            hcol_q   <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            col_q    <= 4'b0000;
            x_next_q <= 10'd0;
            y_next_q <= 10'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        x_q    <= x_pos;
                        y_q    <= y_pos;
                        xs_q   <= sxs_s;
                        ys_q   <= sys_s;
                        xd_q   <= x_dir;
                        yd_q   <= y_dir;
                        xr_q   <= x_pos;
                        hcol_q <= 4'b0000;
                        cnt_q  <= 8'd0;
                        busy_q <= 1'b1;
                        if (sxs_s != 10'd0) begin
                            state_q <= ST_HPROBE;
                        end else if (sys_s != 10'd0) begin
                            state_q <= ST_VPROBE;
                        end else begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            col_q    <= 4'b0000;
                            x_next_q <= x_pos;
                            y_next_q <= y_pos;
                        end
                    end
                end
                ST_HPROBE: begin
                    if (cnt_q == NPV_M1) begin
                        cnt_q   <= 8'd0;
                        state_q <= ST_HWAIT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_HWAIT: begin
                    if (cnt_q == LAT_M1) begin
                        cnt_q  <= 8'd0;
                        xr_q   <= x_res_s;
                        hcol_q <= hcol_s;
                        if (ys_q != 10'd0) begin
                            state_q <= ST_VPROBE;
                        end else begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            col_q    <= hcol_s;
                            x_next_q <= x_res_s;
                            y_next_q <= y_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_VPROBE: begin
                    if (cnt_q == NPH_M1) begin
                        cnt_q   <= 8'd0;
                        state_q <= ST_VWAIT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_VWAIT: begin
                    if (cnt_q == LAT_M1) begin
                        cnt_q    <= 8'd0;
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        col_q    <= hcol_q | vcol_s;
                        x_next_q <= xr_q;
                        y_next_q <= y_res_s;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= 8'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign col    = col_q;
    assign x_next = x_next_q;
    assign y_next = y_next_q;

endmodule

// File: tb/tb_entity_resolver.sv
// Directed bench for entity_resolver: three instances (defaults, MAP_LAT=3,
// 48x48 hitbox on 16-pixel tiles) each backed by a small tile-map model.
module tb_entity_resolver;
    import entity_resolver_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start_v;
    logic [9:0] x_pos, y_pos;
    logic [4:0] x_spd, y_spd;
    logic       x_dir, y_dir;
    int         mode_a, mode_b, mode_c;
    logic       cap_clr;

    logic [9:0] map_x_a, map_y_a, map_x_b, map_y_b, map_x_c, map_y_c;
    logic       map_req_a, map_req_b, map_req_c;
    logic [2:0] map_type_a, map_type_b, map_type_c, d0_b, d1_b;
    logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [3:0] col_a, col_b, col_c;
    logic [9:0] x_next_a, y_next_a, x_next_b, y_next_b, x_next_c, y_next_c;

    entity_resolver u_dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .x_pos(x_pos), .y_pos(y_pos),
        .x_spd(x_spd), .y_spd(y_spd), .x_dir(x_dir), .y_dir(y_dir),
        .map_x(map_x_a), .map_y(map_y_a), .map_req(map_req_a), .map_type(map_type_a),
        .busy(busy_a), .done(done_a), .col(col_a), .x_next(x_next_a), .y_next(y_next_a)
    );

    entity_resolver #(.MAP_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .x_pos(x_pos), .y_pos(y_pos),
        .x_spd(x_spd), .y_spd(y_spd), .x_dir(x_dir), .y_dir(y_dir),
        .map_x(map_x_b), .map_y(map_y_b), .map_req(map_req_b), .map_type(map_type_b),
        .busy(busy_b), .done(done_b), .col(col_b), .x_next(x_next_b), .y_next(y_next_b)
    );

    entity_resolver #(.HB_W(48), .HB_H(48), .TILE(16)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .x_pos(x_pos), .y_pos(y_pos),
        .x_spd(x_spd), .y_spd(y_spd), .x_dir(x_dir), .y_dir(y_dir),
        .map_x(map_x_c), .map_y(map_y_c), .map_req(map_req_c), .map_type(map_type_c),
        .busy(busy_c), .done(done_c), .col(col_c), .x_next(x_next_c), .y_next(y_next_c)
    );

    // Tile map: 1 = solid column 5, 2 = one-way row 3, 3 = solid row 3, else empty
    function automatic logic [2:0] tile_at(input int mode, input logic [9:0] x,
                                           input logic [9:0] y, input int sh);
        int tx;
        int ty;
        tx = int'(x) >> sh;
        ty = int'(y) >> sh;
        case (mode)
            1:       return (tx == 5) ? BT_SOLID : BT_EMPTY;
            2:       return (ty == 3) ? BT_ONEWAY : BT_EMPTY;
            3:       return (ty == 3) ? BT_SOLID : BT_EMPTY;
            default: return BT_EMPTY;
        endcase
    endfunction

    // Map responses; cycles that answer no probe carry a solid type as bait
    always @(posedge clk) begin
        map_type_a <= map_req_a ? tile_at(mode_a, map_x_a, map_y_a, 5) : BT_SOLID;
        d0_b       <= map_req_b ? tile_at(mode_b, map_x_b, map_y_b, 5) : BT_SOLID;
        d1_b       <= d0_b;
        map_type_b <= d1_b;
        map_type_c <= map_req_c ? tile_at(mode_c, map_x_c, map_y_c, 4) : BT_SOLID;
    end

    // Count done pulses on instance a
    int dcnt_a = 0;
    always @(posedge clk) begin
        if (done_a) dcnt_a <= dcnt_a + 1;
    end

    // Record probe addresses of instance c
    int pidx = 0;
    logic [9:0] px [0:7];
    logic [9:0] py [0:7];
    always @(posedge clk) begin
        if (cap_clr) begin
            pidx <= 0;
        end else if (map_req_c && pidx < 8) begin
            px[pidx] <= map_x_c;
            py[pidx] <= map_y_c;
            pidx     <= pidx + 1;
        end
    end

    int         sel;
    logic       done_s, busy_s;
    logic [3:0] col_s;
    logic [9:0] xn_s, yn_s;
    // Route the selected instance's outputs to the common checking path
    always_comb begin
        case (sel)
            1: begin done_s = done_b; busy_s = busy_b; col_s = col_b; xn_s = x_next_b; yn_s = y_next_b; end
            2: begin done_s = done_c; busy_s = busy_c; col_s = col_c; xn_s = x_next_c; yn_s = y_next_c; end
            default: begin done_s = done_a; busy_s = busy_a; col_s = col_a; xn_s = x_next_a; yn_s = y_next_a; end
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic setp(input logic [9:0] x, input logic [9:0] y, input logic [4:0] xs,
                        input logic xd, input logic [4:0] ys, input logic yd);
        x_pos = x; y_pos = y; x_spd = xs; x_dir = xd; y_spd = ys; y_dir = yd;
    endtask

    // Pulse start on one instance (called at a negedge) and check latency and results
    task automatic run(input int s, input string tag, input int exp_lat,
                       input logic [3:0] exp_col, input logic [9:0] exp_x, input logic [9:0] exp_y);
        int lat;
        sel        = s;
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v = 3'b000;
        lat     = 1;
        check({tag, " busy"}, 32'(busy_s), 32'd1);
        while (!done_s && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " lat"}, lat, exp_lat);
        check({tag, " col"}, 32'(col_s), 32'(exp_col));
        check({tag, " x"}, 32'(xn_s), 32'(exp_x));
        check({tag, " y"}, 32'(yn_s), 32'(exp_y));
        @(negedge clk);
        check({tag, " idle"}, 32'({busy_s, done_s}), 32'd0);
    endtask

    initial begin
        int lat;
        int d0;
        rst = 1'b1; start_v = 3'b000; cap_clr = 1'b1; sel = 0;
        mode_a = 0; mode_b = 0; mode_c = 0;
        setp(10'd0, 10'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst busy_done", 32'({busy_a, done_a, map_req_a}), 32'd0);
        check("rst map_xy", 32'({map_x_a, map_y_a}), 32'd0);
        check("rst results", 32'({col_a, x_next_a, y_next_a}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        mode_a = 1;
        setp(10'd120, 10'd100, 5'd10, 1'b1, 5'd0, 1'b0);
        run(0, "solid_right", 4, 4'b0100, 10'd128, 10'd100);
        setp(10'd200, 10'd100, 5'd15, 1'b0, 5'd0, 1'b0);
        run(0, "solid_left", 4, 4'b0001, 10'd192, 10'd100);
        setp(10'd120, 10'd100, 5'd10, 1'b1, 5'd4, 1'b0);
        run(0, "diag_resolved_x", 7, 4'b0100, 10'd128, 10'd104);

        mode_a = 2;
        setp(10'd40, 10'd90, 5'd0, 1'b1, 5'd8, 1'b0);
        run(0, "oneway_down", 4, 4'b0010, 10'd40, 10'd95);
        setp(10'd40, 10'd90, 5'd0, 1'b1, 5'd8, 1'b1);
        run(0, "oneway_up", 4, 4'b0000, 10'd40, 10'd82);

        mode_a = 3;
        setp(10'd40, 10'd165, 5'd0, 1'b1, 5'd10, 1'b1);
        run(0, "solid_up", 4, 4'b1000, 10'd40, 10'd159);
        setp(10'd333, 10'd444, 5'd0, 1'b1, 5'd0, 1'b0);
        run(0, "zero_speed", 1, 4'b0000, 10'd333, 10'd444);

        mode_a = 0;
        setp(10'd1020, 10'd5, 5'd10, 1'b1, 5'd10, 1'b1);
        run(0, "wrap", 7, 4'b0000, 10'd6, 10'd1019);

        // Second start while busy must be ignored
        mode_a = 1;
        sel    = 0;
        d0     = dcnt_a;
        setp(10'd120, 10'd100, 5'd10, 1'b1, 5'd0, 1'b0);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v = 3'b000;
        @(negedge clk);
        setp(10'd500, 10'd500, 5'd3, 1'b0, 5'd3, 1'b0);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v = 3'b000;
        lat = 3;
        while (!done_s && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("restart lat", lat, 4);
        check("restart col", 32'(col_a), 32'd4);
        check("restart x", 32'(x_next_a), 32'd128);
        repeat (12) @(negedge clk);
        check("restart one_done", dcnt_a - d0, 1);

        // Reset during VWAIT aborts silently
        mode_a = 0;
        setp(10'd100, 10'd100, 5'd5, 1'b1, 5'd5, 1'b0);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v = 3'b000;
        repeat (5) @(negedge clk);
        check("abort busy_mid", 32'(busy_a), 32'd1);
        d0  = dcnt_a;
        rst = 1'b1;
        @(negedge clk);
        check("abort status", 32'({busy_a, done_a, map_req_a}), 32'd0);
        check("abort results", 32'({col_a, x_next_a, y_next_a}), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort no_done", dcnt_a - d0, 0);
        run(0, "after_abort", 7, 4'b0000, 10'd105, 10'd105);

        // MAP_LAT = 3, both axes, free map
        setp(10'd200, 10'd300, 5'd7, 1'b0, 5'd12, 1'b1);
        run(1, "lat3", 11, 4'b0000, 10'd193, 10'd288);

        // 48x48 hitbox on 16-pixel tiles: four probes along the left edge
        mode_c  = 1;
        cap_clr = 1'b1;
        @(negedge clk);
        cap_clr = 1'b0;
        setp(10'd100, 10'd200, 5'd6, 1'b0, 5'd0, 1'b0);
        run(2, "big", 6, 4'b0001, 10'd96, 10'd200);
        check("big nprobe", pidx, 4);
        check("big x0", 32'(px[0]), 32'd94);
        check("big y0", 32'(py[0]), 32'd153);
        check("big y1", 32'(py[1]), 32'd169);
        check("big y2", 32'(py[2]), 32'd185);
        check("big y3", 32'(py[3]), 32'd200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
